divider: RTL and testbench



---
 rtl/divider_pkg.sv | 25 ++
 rtl/divider_if.sv | 35 +++
 rtl/divider_step.sv | 34 +++
 rtl/divider.sv | 178 +++++++++++++++++
 tb/tb_divider.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared types and helpers for the iterative restoring divider.
//   div_state_t : control FSM states (IDLE, RUN)
//   MAX_WIDTH   : widest operand the abs_val helper can handle
//   abs_val     : conditional two's-complement negate, used both to take
//                 operand magnitudes and to re-apply result signs
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int MAX_WIDTH = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } div_state_t;

  // Callers zero-extend into MAX_WIDTH and truncate the result back to their
  // own width; negation modulo 2^MAX_WIDTH truncates to the correct value.
  function automatic logic [MAX_WIDTH-1:0] abs_val(input logic [MAX_WIDTH-1:0] x,
                                                   input logic                 neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/divider_if.sv
// -----------------------------------------------------------------------------
// divider_if
// Pulse-style issue/result bundle shared with the iterative multiplier.
//   valid_in    : one-cycle start pulse, a/b sampled on the same edge
//   a, b        : dividend, divisor
//   valid_out   : one-cycle result pulse
//   q, r        : quotient, remainder (held until the next result)
//   div_by_zero : last result was produced with b == 0
//   busy        : a division is in progress
// master = issuer, slave = divider.
// -----------------------------------------------------------------------------
interface divider_if #(
  parameter int WIDTH = 32
);

  logic             valid_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             valid_out;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_by_zero;
  logic             busy;

  modport master (
    output valid_in, a, b,
    input  valid_out, q, r, div_by_zero, busy
  );

  modport slave (
    input  valid_in, a, b,
    output valid_out, q, r, div_by_zero, busy
  );

endinterface

// File: rtl/divider_step.sv
// -----------------------------------------------------------------------------
// div_step
// One purely combinational restoring-division step.
//   i_rem     : current partial remainder (always < divisor, so WIDTH bits)
//   i_dvd_msb : next dividend bit to bring down
//   i_divisor : divisor magnitude
//   o_rem     : next partial remainder
//   o_q_bit   : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_dvd_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q_bit
);

  // The shifted remainder needs one extra bit: 2*rem+1 can reach 2*divisor-1,
  // which overflows WIDTH bits when the divisor is large.
  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;

  always_comb begin
    w_shifted = {i_rem, i_dvd_msb};
    w_diff    = w_shifted - {1'b0, i_divisor};
    o_q_bit   = (w_shifted >= {1'b0, i_divisor});
    // After a successful subtract the difference is < divisor, so the top bit
    // is zero and dropping it is lossless.
    o_rem     = o_q_bit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
// Iterative restoring integer divider, one quotient bit per clock.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : divider_if.slave (valid_in/a/b in; valid_out/q/r/div_by_zero/busy
//           out). The interface WIDTH must equal this module's WIDTH.
// Parameters:
//   WIDTH  : operand/result width, 2..div_pkg::MAX_WIDTH
//   SIGNED : 0 = unsigned, 1 = two's-complement truncating division
// Latency: WIDTH cycles for a normal result, 1 cycle for a zero divisor.
// A valid_in while busy aborts the current division and restarts.
// -----------------------------------------------------------------------------
module divider
  import div_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 0
) (
  input  logic      clk,
  input  logic      rst_n,
  divider_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  div_state_t       r_state;
  div_state_t       w_state_next;
  logic             w_busy;

  logic [WIDTH-1:0] r_dvd;      // dividend magnitude; quotient bits shift in at the LSB
  logic [WIDTH-1:0] r_div;      // divisor magnitude
  logic [WIDTH-1:0] r_rem;      // partial remainder
  logic [CNT_W-1:0] r_cnt;      // step counter
  logic             r_zero;     // current operation has a zero divisor
  logic             r_q_neg;    // negate quotient at completion
  logic             r_r_neg;    // negate remainder at completion

  logic             r_valid_out;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dbz;

  // ---------------------------------------------------------------------------
  // Operand conditioning
  // ---------------------------------------------------------------------------
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;

  assign w_a_neg = (SIGNED != 0) && bus.a[WIDTH-1];
  assign w_b_neg = (SIGNED != 0) && bus.b[WIDTH-1];
  // The most-negative value negates to itself, which is its correct unsigned
  // magnitude, so no special case is needed for it.
  assign w_mag_a = WIDTH'(abs_val(MAX_WIDTH'(bus.a), w_a_neg));
  assign w_mag_b = WIDTH'(abs_val(MAX_WIDTH'(bus.b), w_b_neg));

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] w_rem_next;
  logic             w_q_bit;
  logic             w_last;
  logic [WIDTH-1:0] w_q_final;
  logic [WIDTH-1:0] w_q_signed;
  logic [WIDTH-1:0] w_r_signed;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_dvd_msb (r_dvd[WIDTH-1]),
    .i_divisor (r_div),
    .o_rem     (w_rem_next),
    .o_q_bit   (w_q_bit)
  );

  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_q_final  = {r_dvd[WIDTH-2:0], w_q_bit};
  assign w_q_signed = WIDTH'(abs_val(MAX_WIDTH'(w_q_final), r_q_neg));
  assign w_r_signed = WIDTH'(abs_val(MAX_WIDTH'(w_rem_next), r_r_neg));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // sees the pre-edge value of every other register, independent of order.
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: the default assignment first guarantees no path leaves the
    // variable unassigned, so no latch is inferred.
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (bus.valid_in) w_state_next = RUN;
      RUN: begin
        if (bus.valid_in)          w_state_next = RUN;   // abort and restart
        else if (r_zero || w_last) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_busy = (r_state == RUN);
  end

  // ---------------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register here is a plain flop (no memory array), so all of
      // them are reset; a mid-operation reset must leave nothing to complete.
      r_dvd       <= '0;
      r_div       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_zero      <= 1'b0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_valid_out <= 1'b0;
      r_q         <= '0;
      r_r         <= '0;
      r_dbz       <= 1'b0;
    end else begin
      r_valid_out <= 1'b0;
      if (bus.valid_in) begin
        // A zero divisor keeps the raw dividend so it can be returned as r.
        r_dvd   <= (bus.b == '0) ? bus.a : w_mag_a;
        r_div   <= w_mag_b;
        r_rem   <= '0;
        r_cnt   <= '0;
        r_zero  <= (bus.b == '0);
        r_q_neg <= w_a_neg ^ w_b_neg;
        r_r_neg <= w_a_neg;
      end else if (r_state == RUN) begin
        if (r_zero) begin
          r_q         <= '1;
          r_r         <= r_dvd;
          r_dbz       <= 1'b1;
          r_valid_out <= 1'b1;
        end else begin
          r_rem <= w_rem_next;
          r_dvd <= w_q_final;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_q         <= w_q_signed;
            r_r         <= w_r_signed;
            r_dbz       <= 1'b0;
            r_valid_out <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.valid_out   = r_valid_out;
  assign bus.q           = r_q;
  assign bus.r           = r_r;
  assign bus.div_by_zero = r_dbz;
  assign bus.busy        = w_busy;

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider
// Scoreboard bench for divider: one unsigned and one signed 32-bit instance.
// Stimulus pushes hand-computed expected results (with the cycle they are due)
// into a per-instance queue; monitors pop and compare on every valid_out.
// -----------------------------------------------------------------------------
module tb_divider;

  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  divider_if #(.WIDTH(W)) u_if ();
  divider_if #(.WIDTH(W)) s_if ();

  divider #(.WIDTH(W), .SIGNED(0)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  divider #(.WIDTH(W), .SIGNED(1)) s_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s_if.slave)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           due;
  } exp_t;

  exp_t uq[$];
  exp_t sq[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one start pulse at the current negedge; accept happens on the next
  // posedge. When push is set, the expected result is queued with its due cycle.
  task automatic issue(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic push, input logic [W-1:0] q, input logic [W-1:0] r,
                       input logic dbz);
    exp_t e;
    e.q   = q;
    e.r   = r;
    e.dbz = dbz;
    e.due = cyc + 1 + ((b == '0) ? 1 : W);
    if (sel) begin
      s_if.a = a; s_if.b = b; s_if.valid_in = 1'b1;
      if (push) sq.push_back(e);
    end else begin
      u_if.a = a; u_if.b = b; u_if.valid_in = 1'b1;
      if (push) uq.push_back(e);
    end
    @(negedge clk);
    u_if.valid_in = 1'b0;
    s_if.valid_in = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && (uq.size() != 0 || sq.size() != 0); i++) @(negedge clk);
    if (uq.size() != 0 || sq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=%0d/%0d pending expected=0", name, uq.size(), sq.size());
      uq.delete();
      sq.delete();
    end
  endtask

  // Monitors
  always @(negedge clk) begin
    exp_t e;
    if (u_if.valid_out) begin
      if (uq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL u_unexpected_valid_out actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        e = uq.pop_front();
        check("u_q",       u_if.q,           e.q);
        check("u_r",       u_if.r,           e.r);
        check("u_dbz",     u_if.div_by_zero, e.dbz);
        check("u_busy_out", u_if.busy,       0);
        check("u_latency", cyc,              e.due);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (s_if.valid_out) begin
      if (sq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL s_unexpected_valid_out actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        e = sq.pop_front();
        check("s_q",       s_if.q,           e.q);
        check("s_r",       s_if.r,           e.r);
        check("s_dbz",     s_if.div_by_zero, e.dbz);
        check("s_busy_out", s_if.busy,       0);
        check("s_latency", cyc,              e.due);
      end
    end
  end

  initial begin
    logic seen;
    u_if.valid_in = 1'b0; u_if.a = '0; u_if.b = '0;
    s_if.valid_in = 1'b0; s_if.a = '0; s_if.b = '0;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_q",         u_if.q,           0);
    check("rst_r",         u_if.r,           0);
    check("rst_dbz",       u_if.div_by_zero, 0);
    check("rst_valid_out", u_if.valid_out,   0);
    check("rst_busy",      u_if.busy,        0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic unsigned division
    issue(0, 32'd100, 32'd7, 1, 32'd14, 32'd2, 0);
    check("u_busy_run", u_if.busy, 1);
    drain("basic");

    // Max dividend, divisor one; then zero divisor
    issue(0, 32'hFFFF_FFFF, 32'd1, 1, 32'hFFFF_FFFF, 32'd0, 0);
    drain("maxdiv");
    issue(0, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 32'd5, 1);
    drain("zero");
    repeat (3) @(negedge clk);
    check("hold_q",   u_if.q,           32'hFFFF_FFFF);
    check("hold_r",   u_if.r,           32'd5);
    check("hold_dbz", u_if.div_by_zero, 1);

    // Signed truncating division, including most-negative / -1
    issue(1, 32'hFFFF_FFF9, 32'd2,        1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    drain("s1");
    issue(1, 32'd7,         32'hFFFF_FFFE, 1, 32'hFFFF_FFFD, 32'd1,        0);
    drain("s2");
    issue(1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 32'd0,        0);
    drain("s3");

    // Restart: second accept ten cycles after the first; flag clears after /0
    issue(0, 32'd100, 32'd7, 0, '0, '0, 0);
    repeat (9) @(negedge clk);
    issue(0, 32'd50, 32'd5, 1, 32'd10, 32'd0, 0);
    drain("restart");

    // Reset mid-operation
    issue(0, 32'd100, 32'd7, 0, '0, '0, 0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_q",         u_if.q,           0);
    check("midrst_r",         u_if.r,           0);
    check("midrst_dbz",       u_if.div_by_zero, 0);
    check("midrst_busy",      u_if.busy,        0);
    check("midrst_valid_out", u_if.valid_out,   0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // Back-to-back: new valid_in in the valid_out cycle
    issue(0, 32'd100, 32'd7, 1, 32'd14, 32'd2, 0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (u_if.valid_out) begin
        seen = 1'b1;
        break;
      end
    end
    check("b2b_seen", seen, 1);
    if (seen) begin
      issue(0, 32'd9, 32'd4, 1, 32'd2, 32'd1, 0);
      check("b2b_hold_q",  u_if.q,    32'd14);
      check("b2b_hold_r",  u_if.r,    32'd2);
      check("b2b_busy",    u_if.busy, 1);
    end
    drain("b2b");

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
